register_bank_rd: RTL
=====================

REGISTER_BANK_RD -- requirements
Module: register_bank_rd

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and of every data port.
REQ-002 Parameter ADDR_W, default 5, register address width; bank depth is 2**ADDR_W.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; port names follow the codebase (clk, reset).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 reg_write  input  1  write enable for the write port.
REQ-007 write_reg  input  ADDR_W  destination register index.
REQ-008 write_data  input  DATA_W  write-back data from the write-data selector.
REQ-009 read_reg1  input  ADDR_W  rs index.
REQ-010 read_reg2  input  ADDR_W  rt index.
REQ-011 a_load  input  1  capture port-1 read value into A.
REQ-012 b_load  input  1  capture port-2 read value into B.
REQ-013 read_data1  output  DATA_W  combinational port-1 read value.
REQ-014 read_data2  output  DATA_W  combinational port-2 read value.
REQ-015 a_out  output  DATA_W  registered A operand.
REQ-016 b_out  output  DATA_W  registered B operand.
REQ-017 wr_count  output  16  count of committed writes, saturating.

Function
REQ-018 The block SHALL hold 2**ADDR_W registers of DATA_W bits.
REQ-019 A write SHALL commit on the rising clk edge when reg_write=1 and write_reg!=0.
REQ-020 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-021 read_data1/2 SHALL be combinational on read_reg1/2: zero-latency read.
REQ-022 Read during a write to the same nonzero index in the same cycle: read_data SHALL present write_data (write-through bypass).
REQ-023 Write-through does not apply to index 0.
REQ-024 On a rising edge with a_load=1, a_out SHALL take read_data1, including any bypassed value; b_out likewise with b_load and read_data2.
REQ-025 a_out and b_out SHALL hold their value when their load signal is 0.
REQ-026 wr_count SHALL increment by 1 per committed write, discarded writes excluded, and SHALL saturate at 16'hFFFF with no wrap.
REQ-027 Simultaneous write and a_load/b_load on the same index: A/B SHALL capture the new data.

Reset
REQ-028 reset=0 SHALL asynchronously clear all registers, a_out, b_out and wr_count to 0.
REQ-029 A reset asserted mid-cycle SHALL abort a pending write; no write SHALL commit on the edge while reset=0.
REQ-030 Register 29 (sp) SHALL reset to 32'd227; all other registers SHALL reset to 0.

Structure
REQ-031 DATA_W, ADDR_W and the sp reset constant (227) SHALL reside in the shared CPU package.
REQ-032 The A/B operand latch SHALL be one sub-module, operand_latch, instantiated twice.

Verification
REQ-033 Reset, then read all 32 indexes -> 0 everywhere except r29 = 227; wr_count = 0.
REQ-034 Write r5 = 0xDEADBEEF with read_reg1 = 5 in the same cycle -> read_data1 = 0xDEADBEEF before the edge; after the edge r5 holds 0xDEADBEEF; wr_count = 1.
REQ-035 Write r0 = 0xFFFFFFFF -> read_data1 (read_reg1 = 0) = 0; wr_count unchanged.
REQ-036 Write r7 = 0x12 with a_load = 1 and read_reg1 = 7 -> a_out = 0x12 after the edge; a_load = 0 for 3 cycles while r7 is rewritten with 0x34 -> a_out stays 0x12.
REQ-037 65540 writes to r1 -> wr_count = 0xFFFF.
REQ-038 Pulse reset low between edges during a write to r3 -> r3 = 0 and a_out = b_out = 0; no commit occurs on the next edge while reset = 0.

Source files
------------

// File: rtl/register_bank_rd_pkg.sv
// register_bank_rd_pkg: shared CPU widths, sp reset image and write-counter helper
package register_bank_rd_pkg;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int SP_IDX = 29;
  localparam int unsigned SP_RESET_VAL = 227;
  localparam logic [15:0] WR_CNT_MAX = 16'hFFFF;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == WR_CNT_MAX) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/register_bank_rd_operand_latch.sv
// operand_latch: load-enabled operand register with asynchronous active-low clear
module operand_latch #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q, data_d;
  // hold unless load is asserted
  always_comb data_d = load_i ? d_i : data_q;
  // capture next operand, clear on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) data_q <= '0;
    else data_q <= data_d;
  assign q_o = data_q;
endmodule

// File: rtl/register_bank_rd.sv
// register_bank_rd: 2-read/1-write register file with write-through bypass, A/B operand latches and write counter
module register_bank_rd
  import register_bank_rd_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              a_load,
  input  logic              b_load,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [15:0]       wr_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [15:0]       wr_count_q, wr_count_d;
  logic              commit;
  assign commit = reg_write && (write_reg != '0);
  // zero-latency reads; a same-cycle commit to the read index is forwarded (never index 0, since commit excludes it)
  always_comb begin
    read_data1 = (commit && read_reg1 == write_reg) ? write_data : regs_q[read_reg1];
    read_data2 = (commit && read_reg2 == write_reg) ? write_data : regs_q[read_reg2];
  end
  // register storage: reset loads the boot image (sp preset), r0 is never written so it stays 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET_VAL) : '0;
    else if (commit) regs_q[write_reg] <= write_data;
  // saturating count of committed writes
  always_comb wr_count_d = commit ? sat_inc(wr_count_q) : wr_count_q;
  // write counter state
  always_ff @(posedge clk or negedge reset)
    if (!reset) wr_count_q <= '0;
    else wr_count_q <= wr_count_d;
  assign wr_count = wr_count_q;
  operand_latch #(.W(DATA_W)) u_a (
    .clk    (clk),
    .reset  (reset),
    .load_i (a_load),
    .d_i    (read_data1),
    .q_o    (a_out)
  );
  operand_latch #(.W(DATA_W)) u_b (
    .clk    (clk),
    .reset  (reset),
    .load_i (b_load),
    .d_i    (read_data2),
    .q_o    (b_out)
  );
endmodule
